// File: rtl/adder_seq.sv
// Sequential 64-bit adder: adds CHUNK bits per cycle over N = 64/CHUNK cycles
// with a valid/ready handshake on both the operand and result sides.
module adder_seq #(
  parameter int CHUNK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        cout
);

  localparam int N    = 64 / CHUNK;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [63:0]       a_r;
  logic [63:0]       b_r;
  logic [63:0]       sum_r;
  logic [63:0]       s_r;
  logic              cout_r;
  logic              carry_r;
  logic [CNTW-1:0]   cnt_r;
  logic              last_s;
  logic [5:0]        base_s;
  logic [CHUNK-1:0]  chunk_a_s;
  logic [CHUNK-1:0]  chunk_b_s;
  logic [CHUNK:0]    chunk_sum_s;
  logic [63:0]       sum_nxt_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign cout      = cout_r;

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Chunk slice selection and ripple of one chunk with the stored carry.
  always_comb begin
    last_s      = (cnt_r == CNTW'(N - 1));
    base_s      = 6'(cnt_r) * 6'(CHUNK);
    chunk_a_s   = a_r[base_s +: CHUNK];
    chunk_b_s   = b_r[base_s +: CHUNK];
    chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, carry_r};
    sum_nxt_s   = sum_r;
    sum_nxt_s[base_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
  end

  // Operand latch, chunk datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= 64'd0;
      b_r     <= 64'd0;
      sum_r   <= 64'd0;
      s_r     <= 64'd0;
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            cnt_r   <= '0;
            carry_r <= 1'b0;
          end
        end
        RUN: begin
          sum_r   <= sum_nxt_s;
          carry_r <= chunk_sum_s[CHUNK];
          cnt_r   <= cnt_r + CNTW'(1);
          // Result outputs only move on the final chunk, i.e. entry to DONE.
          if (last_s) begin
            s_r    <= sum_nxt_s;
            cout_r <= chunk_sum_s[CHUNK];
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
